// File: rtl/nbin_unpack_ctrl.sv
// NBin unpacker sequencer: fetches packed words into two rows and walks a circular
// bit pointer so the unpacker emits one N-bit value per cycle. Optional macro: NBIN_SE_EN.
module nbin_unpack_ctrl #(
   parameter int BIT_WIDTH  = 16,
   parameter int SHIFT_BITS = 5,
   parameter int CNT_BITS   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [SHIFT_BITS-1:0] i_prec,
   input  logic [CNT_BITS-1:0]   i_count,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   output logic [1:0]            o_load,
   output logic [SHIFT_BITS-1:0] o_s,
   output logic [SHIFT_BITS-2:0] o_n,
   output logic [BIT_WIDTH-1:0]  o_se,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int LOG_W   = SHIFT_BITS - 1;
   localparam int PROD_W  = CNT_BITS + SHIFT_BITS;
   localparam int WORDS_W = PROD_W - LOG_W;
   localparam logic [SHIFT_BITS-1:0] ROW_W = SHIFT_BITS'(BIT_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [SHIFT_BITS-1:0] prec_eff_s;
   logic [SHIFT_BITS-1:0] n_r;
   logic [SHIFT_BITS-1:0] ptr_r;
   logic [SHIFT_BITS-1:0] sum_s;
   logic                  wr_row_r;
   logic [1:0]            v_r;
   logic [1:0]            v_nxt_s;
   logic [CNT_BITS-1:0]   vals_left_r;
   logic [WORDS_W-1:0]    words_left_r;
   logic [WORDS_W-1:0]    words_s;
   logic [PROD_W-1:0]     prod_s;
   logic                  start_s;
   logic                  in_ready_s;
   logic                  valid_s;
   logic                  handshake_s;
   logic                  emit_s;
   logic                  cur_row_s;
   logic                  straddle_s;
   logic                  frees_s;
   logic                  last_s;

   assign start_s     = i_start & (state_r == ST_IDLE);
   assign handshake_s = in_ready_s & i_in_valid;
   assign emit_s      = valid_s & i_ready;
   assign cur_row_s   = ptr_r[SHIFT_BITS-1];
   assign sum_s       = {1'b0, ptr_r[SHIFT_BITS-2:0]} + n_r;
   assign straddle_s  = (sum_s > ROW_W);
   // A value ending exactly on the row boundary also releases its row.
   assign frees_s     = (sum_s >= ROW_W);
   assign last_s      = (vals_left_r == CNT_BITS'(1));
   assign prod_s      = PROD_W'(i_count) * PROD_W'(prec_eff_s);
   assign words_s     = prod_s[PROD_W-1:LOG_W] + WORDS_W'(|prod_s[LOG_W-1:0]);

   assign o_in_ready  = in_ready_s;
   assign o_valid     = valid_s;
   assign o_s         = ptr_r;
   assign o_n         = n_r[SHIFT_BITS-2:0];

   // Precision clamp: 0 and anything above the row width mean full width.
   always_comb begin
      prec_eff_s = i_prec;
      if ((i_prec == {SHIFT_BITS{1'b0}}) || (i_prec > ROW_W)) begin
         prec_eff_s = ROW_W;
      end else begin
         prec_eff_s = i_prec;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_start) begin
               state_nxt_s = (i_count != {CNT_BITS{1'b0}}) ? ST_RUN : ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (emit_s && last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: fetch when the write row is free, present when needed rows are full.
   always_comb begin
      in_ready_s = 1'b0;
      valid_s    = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state_r)
         ST_RUN: begin
            in_ready_s = ~v_r[wr_row_r] & (words_left_r != {WORDS_W{1'b0}});
            valid_s    = v_r[cur_row_s] & (~straddle_s | v_r[~cur_row_s]);
            o_busy     = 1'b1;
         end
         ST_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: begin
            in_ready_s = 1'b0;
            valid_s    = 1'b0;
         end
      endcase
   end

   // Row load strobe follows the accepting handshake.
   always_comb begin
      o_load = 2'b00;
      if (handshake_s) begin
         o_load = wr_row_r ? 2'b10 : 2'b01;
      end else begin
         o_load = 2'b00;
      end
   end

   // Row valid flags: the freed row and the loaded row are always distinct.
   always_comb begin
      v_nxt_s = v_r;
      if (emit_s && frees_s) begin
         v_nxt_s[cur_row_s] = 1'b0;
      end else begin
         v_nxt_s[cur_row_s] = v_r[cur_row_s];
      end
      if (handshake_s) begin
         v_nxt_s[wr_row_r] = 1'b1;
      end else begin
         v_nxt_s[wr_row_r] = v_nxt_s[wr_row_r];
      end
   end

   // Pointer, row bookkeeping and job counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_r          <= {SHIFT_BITS{1'b0}};
         ptr_r        <= {SHIFT_BITS{1'b0}};
         wr_row_r     <= 1'b0;
         v_r          <= 2'b00;
         vals_left_r  <= {CNT_BITS{1'b0}};
         words_left_r <= {WORDS_W{1'b0}};
      end else if (start_s) begin
         n_r          <= prec_eff_s;
         ptr_r        <= {SHIFT_BITS{1'b0}};
         wr_row_r     <= 1'b0;
         v_r          <= 2'b00;
         vals_left_r  <= i_count;
         words_left_r <= words_s;
      end else begin
         v_r <= v_nxt_s;
         if (emit_s) begin
            ptr_r       <= ptr_r + n_r;
            vals_left_r <= vals_left_r - CNT_BITS'(1);
         end
         if (handshake_s) begin
            wr_row_r     <= ~wr_row_r;
            words_left_r <= words_left_r - WORDS_W'(1);
         end
      end
   end

`ifdef NBIN_SE_EN
   logic [BIT_WIDTH-1:0] se_r;

   // Upper bits above the value width are flagged for sign extension.
   function automatic logic [BIT_WIDTH-1:0] se_mask(input logic [SHIFT_BITS-1:0] n);
      logic [BIT_WIDTH-1:0] m;
      m = {BIT_WIDTH{1'b0}};
      for (int i = 0; i < BIT_WIDTH; i++) begin
         m[i] = (SHIFT_BITS'(i) >= n);
      end
      return m;
   endfunction

   // Mask is fixed for the whole job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         se_r <= {BIT_WIDTH{1'b0}};
      end else if (start_s) begin
         se_r <= se_mask(prec_eff_s);
      end else begin
         se_r <= se_r;
      end
   end

   assign o_se = se_r;
`else
   assign o_se = {BIT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_nbin_unpack_ctrl.sv
// Directed self-checking bench for nbin_unpack_ctrl.
module tb_nbin_unpack_ctrl;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [4:0]  i_prec;
   logic [15:0] i_count;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [1:0]  o_load;
   logic [4:0]  o_s;
   logic [3:0]  o_n;
   logic [15:0] o_se;
   logic        o_valid;
   logic        i_ready;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;
   logic [15:0] se5_exp;

   nbin_unpack_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_prec(i_prec), .i_count(i_count),
      .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_load(o_load), .o_s(o_s),
      .o_n(o_n), .o_se(o_se), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
      .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check one cycle's outputs, then advance to just after the next rising edge.
   task automatic cyc(input string tag, input logic rdy, input logic [1:0] ld,
                      input logic vld, input logic [4:0] s, input logic bsy, input logic dn);
      #1;
      chk({tag, ".ready"}, 32'(o_in_ready), 32'(rdy));
      chk({tag, ".load"},  32'(o_load),     32'(ld));
      chk({tag, ".valid"}, 32'(o_valid),    32'(vld));
      chk({tag, ".busy"},  32'(o_busy),     32'(bsy));
      chk({tag, ".done"},  32'(o_done),     32'(dn));
      if (vld) chk({tag, ".s"}, 32'(o_s), 32'(s));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".ready"}, 32'(o_in_ready), 32'd0);
      chk({tag, ".load"},  32'(o_load),     32'd0);
      chk({tag, ".s"},     32'(o_s),        32'd0);
      chk({tag, ".n"},     32'(o_n),        32'd0);
      chk({tag, ".se"},    32'(o_se),       32'd0);
      chk({tag, ".valid"}, 32'(o_valid),    32'd0);
      chk({tag, ".busy"},  32'(o_busy),     32'd0);
      chk({tag, ".done"},  32'(o_done),     32'd0);
   endtask

   initial begin
`ifdef NBIN_SE_EN
      se5_exp = 16'hFFE0;
`else
      se5_exp = 16'h0000;
`endif
      rst_n = 1'b0; i_start = 1'b0; i_prec = 5'd0; i_count = 16'd0;
      i_in_valid = 1'b0; i_ready = 1'b0;
      #3;
      chk_reset_outputs("RST");
      #4 rst_n = 1'b1;
      @(posedge clk); #1;

      // N=16, count=4, continuous; a start while busy must be ignored.
      i_in_valid = 1'b1; i_ready = 1'b1;
      i_start = 1'b1; i_prec = 5'd16; i_count = 16'd4;
      cyc("A0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0;
      chk("A1.n", 32'(o_n), 32'd0);
      chk("A1.se", 32'(o_se), 32'd0);
      cyc("A1", 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("A2", 1'b1, 2'b10, 1'b1, 5'd0, 1'b1, 1'b0);
      i_start = 1'b1; i_prec = 5'd5; i_count = 16'd9;
      cyc("A3", 1'b1, 2'b01, 1'b1, 5'd16, 1'b1, 1'b0);
      i_start = 1'b0;
      chk("A4.n", 32'(o_n), 32'd0);
      cyc("A4", 1'b1, 2'b10, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc("A5", 1'b0, 2'b00, 1'b1, 5'd16, 1'b1, 1'b0);
      cyc("A6", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("A7", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      // N=5, count=7: three words, values wait on the MS row and on the third word.
      i_start = 1'b1; i_prec = 5'd5; i_count = 16'd7; i_in_valid = 1'b0;
      cyc("B0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0; i_in_valid = 1'b1;
      chk("B1.n", 32'(o_n), 32'd5);
      chk("B1.se", 32'(o_se), 32'(se5_exp));
      cyc("B1", 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
      i_in_valid = 1'b0;
      cyc("B2", 1'b1, 2'b00, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc("B3", 1'b1, 2'b00, 1'b1, 5'd5, 1'b1, 1'b0);
      cyc("B4", 1'b1, 2'b00, 1'b1, 5'd10, 1'b1, 1'b0);
      i_in_valid = 1'b1;
      cyc("B5", 1'b1, 2'b10, 1'b0, 5'd15, 1'b1, 1'b0);
      cyc("B6", 1'b0, 2'b00, 1'b1, 5'd15, 1'b1, 1'b0);
      i_in_valid = 1'b0;
      cyc("B7", 1'b1, 2'b00, 1'b1, 5'd20, 1'b1, 1'b0);
      cyc("B8", 1'b1, 2'b00, 1'b1, 5'd25, 1'b1, 1'b0);
      i_in_valid = 1'b1;
      cyc("B9", 1'b1, 2'b01, 1'b0, 5'd30, 1'b1, 1'b0);
      cyc("B10", 1'b0, 2'b00, 1'b1, 5'd30, 1'b1, 1'b0);
      cyc("B11", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("B12", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      // N=3, count=6, downstream stalls three cycles on the third value.
      i_start = 1'b1; i_prec = 5'd3; i_count = 16'd6; i_in_valid = 1'b1; i_ready = 1'b1;
      cyc("C0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0;
      cyc("C1", 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("C2", 1'b1, 2'b10, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc("C3", 1'b0, 2'b00, 1'b1, 5'd3, 1'b1, 1'b0);
      i_ready = 1'b0;
      cyc("C4", 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 1'b0);
      cyc("C5", 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 1'b0);
      cyc("C6", 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 1'b0);
      i_ready = 1'b1;
      cyc("C7", 1'b0, 2'b00, 1'b1, 5'd6, 1'b1, 1'b0);
      cyc("C8", 1'b0, 2'b00, 1'b1, 5'd9, 1'b1, 1'b0);
      cyc("C9", 1'b0, 2'b00, 1'b1, 5'd12, 1'b1, 1'b0);
      cyc("C10", 1'b0, 2'b00, 1'b1, 5'd15, 1'b1, 1'b0);
      cyc("C11", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("C12", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      // count=0: immediate done, no fetch.
      i_start = 1'b1; i_prec = 5'd7; i_count = 16'd0;
      cyc("D0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0;
      cyc("D1", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("D2", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      // i_prec=0 behaves as full width.
      i_start = 1'b1; i_prec = 5'd0; i_count = 16'd2;
      cyc("E0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0;
      chk("E1.n", 32'(o_n), 32'd0);
      chk("E1.se", 32'(o_se), 32'd0);
      cyc("E1", 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("E2", 1'b1, 2'b10, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc("E3", 1'b0, 2'b00, 1'b1, 5'd16, 1'b1, 1'b0);
      cyc("E4", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
      cyc("E5", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      // Asynchronous reset after three of ten N=5 values.
      i_start = 1'b1; i_prec = 5'd5; i_count = 16'd10;
      cyc("F0", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      i_start = 1'b0;
      cyc("F1", 1'b1, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("F2", 1'b1, 2'b10, 1'b1, 5'd0, 1'b1, 1'b0);
      cyc("F3", 1'b0, 2'b00, 1'b1, 5'd5, 1'b1, 1'b0);
      cyc("F4", 1'b0, 2'b00, 1'b1, 5'd10, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("F5");
      rst_n = 1'b1;
      cyc("F6", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
      cyc("F7", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nbin_unpack_ctrl.md
# nbin_unpack_ctrl

Sequencer that drives the NBin reduced-precision unpacker. Takes packed 16-bit words from the NBin buffer through a valid/ready handshake and tracks a 32-bit circular bit pointer across the unpacker's two rows. Each cycle it issues row loads, shift width, precision and sign-extension mask so the unpacker emits one N-bit value per cycle. It also flags each valid unpacked value to the downstream NFU input stage.

## Interface
- BIT_WIDTH, 16, word and value width; rows are BIT_WIDTH bits each.
- SHIFT_BITS, 5, log2(2*BIT_WIDTH); width of the circular bit pointer.
- CNT_BITS, 16, width of the value count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; latches i_prec and i_count; ignored while o_busy.
- i_prec  in  SHIFT_BITS  precision N, legal 1..16; 0 or >16 is treated as 16.
- i_count  in  CNT_BITS  number of values to unpack.
- i_in_valid  in  1  packed word available from the NBin buffer.
- o_in_ready  out  1  controller accepts a word this cycle; the word is consumed when valid&ready.
- o_load  out  2  unpacker row load: bit0 = LS row (bits 15:0), bit1 = MS row (bits 31:16); at most one bit set.
- o_s  out  SHIFT_BITS  unpacker shift = bit pointer of current value's LSB.
- o_n  out  SHIFT_BITS-1  N[3:0] (N=16 encodes as 0).
- o_se  out  BIT_WIDTH  sign-extension mask to unpacker.
- o_valid  out  1  unpacker output holds a valid value this cycle.
- i_ready  in  1  downstream accepts value; a value is emitted when o_valid&i_ready.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle pulse after the last value is emitted.

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on i_start (i_count≠0); IDLE→DONE on i_start with i_count=0; RUN→DONE on the emission of the last value; DONE→IDLE unconditionally (o_done=1 in DONE).
- On start: ptr=0, wr_row=0, row valid flags v[1:0]=0, vals_left=i_count, words_left=ceil(i_count*N/16) (21-bit product, computed in the start cycle).
- Load: o_in_ready = RUN & ~v[wr_row] & (words_left≠0). On handshake: o_load[wr_row]=1, v[wr_row] set, wr_row toggles, words_left decrements. o_load is combinational from the handshake and is aligned with the unpacker's latching edge.
- Rows needed for the value at ptr: row ptr[4]; also row ~ptr[4] if ptr[3:0]+N>16. o_valid = RUN & all needed rows valid.
- Emit (o_valid&i_ready): ptr←(ptr+N) mod 32; if the new pointer leaves a row, or ptr[3:0]+N=16 exactly, that row's valid flag clears at the same edge; vals_left decrements.
- o_s=ptr, o_n=N[3:0] are held constant while o_valid & ~i_ready; o_se is held stable under backpressure.
- Trailing unused bits of the final word are discarded; rows are invalidated at start.

## Timing
- Reset: state=IDLE, o_in_ready=0, o_load=0, o_s=0, o_n=0, o_se=0, o_valid=0, o_busy=0, o_done=0, all counters 0.
- A word accepted at edge t is usable for o_valid in cycle t+1.
- A row freed at edge t may be reloaded starting in cycle t+1. A load and an emit of a different row may occur in the same cycle.
- Steady state: 1 value/cycle for any N given continuous i_in_valid and i_ready. The first value is emitted 2 cycles after i_start (1 word load), or 3 cycles if it straddles rows.
- Asynchronous reset mid-job aborts immediately to reset values; no o_done is issued.

## Configuration
- NBIN_SE_EN defined: o_se has bits [BIT_WIDTH-1:N] set when N<16, and is 0 when N=16.
- NBIN_SE_EN undefined: o_se is tied to 0 and the unpacker passes raw window bits.

## Test plan
- Reset mid-RUN (N=5, count=10 after 3 values) -> all outputs at reset values next cycle, no o_done, IDLE.
- N=16, count=4, continuous valid/ready -> loads LS,MS,LS,MS; o_s=0,16,0,16; 4 values on consecutive cycles; o_done 1 cycle after last.
- N=5, count=7 (35 bits) -> exactly 3 words fetched; o_s=0,5,10,15,20,25,30; value at ptr 15 waits for MS row; value at ptr 30 waits for the third word in the LS row; o_se=0xFFE0 with NBIN_SE_EN.
- N=3, count=6, i_ready low for 3 cycles at value 2 -> o_s held at 6, o_valid held, no pointer advance; all 6 values emitted in order.
- i_count=0 -> o_done pulse 1 cycle after start, o_in_ready never asserted; i_start while busy -> ignored, job continues unchanged.
- i_prec=0 -> behaves as N=16, o_n=0, o_se=0.
